wpa2_block_loader: RTL and testbench

Loads one 512-bit SHA-1 message block, word by word, from software-driven PIO outputs and streams it to the hash core. It sits directly downstream of the 8-bit address PIO and the 32-bit data PIO, which it consumes together with a 1-bit strobe PIO. On a start command it presents the 16 buffered words on a valid/ready stream to the SHA-1 message-schedule stage.

---
 rtl/wpa2_block_loader.sv | 148 ++++++++++++++
 tb/tb_wpa2_block_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wpa2_block_loader.sv
// rtl/wpa2_block_loader.sv - PIO-fed 512-bit SHA-1 message block loader and streamer (optional byte swap: WPA2_LOADER_BSWAP_EN)
module wpa2_block_loader #(
    parameter int WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pio_address,
    input  logic [31:0] pio_data,
    input  logic        pio_strobe,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic [15:0] loaded,
    output logic        overrun,
    output logic        done
);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    localparam logic [3:0]  LAST_IDX  = 4'(WORDS - 1);
    localparam logic [15:0] WORD_MASK = 16'((33'd1 << WORDS) - 33'd1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        strobe_q, strobe_d;
    logic [31:0] buf_q [16];
    logic [31:0] buf_d [16];
    logic [15:0] loaded_q, loaded_d;
    logic        overrun_q, overrun_d;
    logic        done_q, done_d;

    logic        strobe_edge;
    logic        cmd_bit;
    logic        clr_bit;
    logic [3:0]  widx;
    logic        widx_ok;
    logic [31:0] wdata;
    logic        streaming;
    logic        unused_addr_bits;

    assign strobe_edge      = pio_strobe & ~strobe_q;
    assign cmd_bit          = pio_address[7];
    assign clr_bit          = pio_address[6];
    assign widx             = pio_address[3:0];
    assign widx_ok          = ({1'b0, widx} < 5'(WORDS));
    assign streaming        = (state_q == S_STREAM);
    assign unused_addr_bits = ^pio_address[5:4];

`ifdef WPA2_LOADER_BSWAP_EN
    assign wdata = {pio_data[7:0], pio_data[15:8], pio_data[23:16], pio_data[31:24]};
`else
    assign wdata = pio_data;
`endif

    // Outputs come only from registered state so m_ready never reaches m_valid combinationally.
    assign m_valid = streaming;
    assign busy    = streaming;
    assign m_data  = streaming ? buf_q[idx_q] : 32'd0;
    assign m_last  = streaming && (idx_q == LAST_IDX);
    assign loaded  = loaded_q & WORD_MASK;
    assign overrun = overrun_q;
    assign done    = done_q;

    // Next-state: FSM stepping on handshakes plus PIO command decode on the strobe rising edge.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        strobe_d  = pio_strobe;
        buf_d     = buf_q;
        loaded_d  = loaded_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (strobe_edge && cmd_bit && !clr_bit) begin
                    state_d = S_STREAM;
                    idx_d   = 4'd0;
                end
            end
            S_STREAM: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d  = S_IDLE;
                        idx_d    = 4'd0;
                        loaded_d = 16'd0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
            end
        endcase

        if (strobe_edge) begin
            if (!cmd_bit) begin
                // Writes are only accepted while idle and in range; anything else is flagged.
                if (!widx_ok || streaming) begin
                    overrun_d = 1'b1;
                end else begin
                    buf_d[widx]    = wdata;
                    loaded_d[widx] = 1'b1;
                end
            end else if (clr_bit) begin
                // Clear only touches status; an active stream keeps going.
                overrun_d = 1'b0;
                loaded_d  = 16'd0;
            end else if (streaming) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State register with asynchronous active-high reset; reset abandons any stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            strobe_q  <= 1'b0;
            loaded_q  <= 16'd0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 32'd0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            strobe_q  <= strobe_d;
            loaded_q  <= loaded_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_wpa2_block_loader.sv
// tb/tb_wpa2_block_loader.sv - directed self-checking bench for wpa2_block_loader
module tb_wpa2_block_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pio_address;
    logic [31:0] pio_data;
    logic        pio_strobe;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic [15:0] loaded;
    logic        overrun;
    logic        done;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [16];

    wpa2_block_loader #(.WORDS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .pio_address (pio_address),
        .pio_data    (pio_data),
        .pio_strobe  (pio_strobe),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .loaded      (loaded),
        .overrun     (overrun),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] stored(input logic [31:0] x);
`ifdef WPA2_LOADER_BSWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Strobe high for one cycle starting at a negedge; returns at the next negedge with strobe low.
    task automatic pio_cmd(input logic [7:0] a, input logic [31:0] d);
        pio_address = a;
        pio_data    = d;
        pio_strobe  = 1'b1;
        @(negedge clk);
        pio_strobe  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] i, input logic [31:0] d);
        pio_cmd({4'h0, i}, d);
        @(negedge clk);
    endtask

    // Called right after START: streams all 16 beats with m_ready high against the model.
    task automatic stream_all(input string tag);
        for (int b = 0; b < 16; b++) begin
            m_ready = 1'b1;
            check($sformatf("%s valid%0d", tag, b), 32'(m_valid), 32'd1);
            check($sformatf("%s data%0d", tag, b), m_data, model[b]);
            check($sformatf("%s last%0d", tag, b), 32'(m_last), (b == 15) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        m_ready = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        check({tag, " loaded_end"}, 32'(loaded), 32'd0);
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_idx;
        int cyc;

        reset       = 1'b1;
        pio_address = 8'h00;
        pio_data    = 32'h0;
        pio_strobe  = 1'b0;
        m_ready     = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        repeat (3) @(negedge clk);

        check("rst m_valid", 32'(m_valid), 32'd0);
        check("rst busy",    32'(busy),    32'd0);
        check("rst m_data",  m_data,       32'd0);
        check("rst m_last",  32'(m_last),  32'd0);
        check("rst loaded",  32'(loaded),  32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        check("rst done",    32'(done),    32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single word at index 3, full-rate stream.
        wr(4'd3, 32'h61626380);
        model[3] = stored(32'h61626380);
        check("blk1 loaded", 32'(loaded), 32'h0008);
        check("blk1 overrun", 32'(overrun), 32'd0);
        m_ready = 1'b1;
        pio_cmd(8'h80, 32'h0);
        stream_all("blk1");

        // Fill all words, stream with m_ready pattern 1,0,0,1,0,0...
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 32'hA000_0000 | 32'(i));
            model[i] = stored(32'hA000_0000 | 32'(i));
        end
        check("bp loaded", 32'(loaded), 32'hFFFF);
        m_ready = 1'b0;
        pio_cmd(8'h80, 32'h0);
        exp_idx = 0;
        cyc = 0;
        while (exp_idx < 16 && cyc < 200) begin
            m_ready = (cyc % 3 == 0);
            check($sformatf("bp valid c%0d", cyc), 32'(m_valid), 32'd1);
            check($sformatf("bp data c%0d", cyc), m_data, model[exp_idx]);
            check($sformatf("bp last c%0d", cyc), 32'(m_last), (exp_idx == 15) ? 32'd1 : 32'd0);
            @(negedge clk);
            if (m_ready) exp_idx++;
            cyc++;
        end
        m_ready = 1'b0;
        check("bp beats", 32'(exp_idx), 32'd16);
        check("bp done", 32'(done), 32'd1);
        check("bp busy_end", 32'(busy), 32'd0);
        check("bp loaded_end", 32'(loaded), 32'd0);
        @(negedge clk);

        // Overrun: write and start during a stalled stream, then clear without aborting.
        pio_cmd(8'h80, 32'h0);
        @(negedge clk);
        pio_cmd(8'h05, 32'h5555_5555);
        @(negedge clk);
        check("ovr write flag", 32'(overrun), 32'd1);
        check("ovr write busy", 32'(busy), 32'd1);
        check("ovr write data0", m_data, model[0]);
        pio_cmd(8'h80, 32'h0);
        @(negedge clk);
        check("ovr start flag", 32'(overrun), 32'd1);
        check("ovr start data0", m_data, model[0]);
        check("ovr start last", 32'(m_last), 32'd0);
        pio_cmd(8'hC0, 32'h0);
        @(negedge clk);
        check("ovr clear flag", 32'(overrun), 32'd0);
        check("ovr clear busy", 32'(busy), 32'd1);
        check("ovr clear data0", m_data, model[0]);
        stream_all("ovr");

        // Held strobe: data changes while strobe stays high must not be written.
        pio_address = 8'h00;
        pio_data    = 32'hDEAD_BEEF;
        pio_strobe  = 1'b1;
        @(negedge clk);
        pio_data    = 32'h1234_5678;
        repeat (9) @(negedge clk);
        pio_strobe  = 1'b0;
        @(negedge clk);
        model[0] = stored(32'hDEAD_BEEF);
        check("held loaded", 32'(loaded), 32'h0001);
        check("held overrun", 32'(overrun), 32'd0);
        pio_cmd(8'h80, 32'h0);
        stream_all("held");

        // Reset in the middle of a stream at beat 7.
        pio_cmd(8'h80, 32'h0);
        for (int b = 0; b < 7; b++) begin
            m_ready = 1'b1;
            @(negedge clk);
        end
        check("mid beat7 data", m_data, model[7]);
        check("mid beat7 valid", 32'(m_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("mid rst valid", 32'(m_valid), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst data", m_data, 32'd0);
        m_ready = 1'b0;
        @(negedge clk);
        check("mid rst done", 32'(done), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        @(negedge clk);
        check("mid post done", 32'(done), 32'd0);
        check("mid post busy", 32'(busy), 32'd0);
        check("mid post loaded", 32'(loaded), 32'd0);
        wr(4'd0, 32'hCAFE_F00D);
        model[0] = stored(32'hCAFE_F00D);
        wr(4'd15, 32'h0000_FFFF);
        model[15] = stored(32'h0000_FFFF);
        check("mid reload loaded", 32'(loaded), 32'h8001);
        pio_cmd(8'h80, 32'h0);
        stream_all("mid");

        // Byte order of stored words.
        wr(4'd2, 32'h1122_3344);
`ifdef WPA2_LOADER_BSWAP_EN
        model[2] = 32'h4433_2211;
`else
        model[2] = 32'h1122_3344;
`endif
        pio_cmd(8'h80, 32'h0);
        stream_all("bswap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
